// File: rtl/usb_rx_bit_frontend.sv
// ---------------------------------------------------------------------------
// usb_rx_bit_frontend
//
// Receive-side bit front end for the hub's serial PID/sequence detectors.
// One sampled line bit arrives per bit-time (qualified by line_valid). The
// block NRZI-decodes it, hunts for the SYNC pattern, strips stuffed bits and
// presents the payload one bit per data_valid pulse, framed by sync_found
// and eop. Stuffing violations and over-long packets are flagged so the hub
// control logic can abandon the packet.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   line_valid   strobe: line_bit_in / se0 carry a new bit-time sample
//   line_bit_in  sampled differential line state (1=J, 0=K), NRZI encoded
//   se0          single-ended zero seen on this strobe
//   data_out     decoded, unstuffed payload bit (holds between pulses)
//   data_valid   1-cycle pulse: data_out is a payload bit (PID first, LSB first)
//   sync_found   1-cycle pulse: SYNC matched, payload starts on next data_valid
//   pkt_active   high while a packet is being received
//   eop          1-cycle pulse: SE0 ended the packet
//   stuff_err    1-cycle pulse: seventh consecutive decoded 1 received
//   babble_err   1-cycle pulse: more than MAX_BITS payload bits without EOP
//
// All outputs are registered; each response appears the cycle after the
// strobe that caused it. At most one pulse output is high in any cycle.
// ---------------------------------------------------------------------------
module usb_rx_bit_frontend #(
    parameter int SYNC_LEN = 8,
    parameter int MAX_BITS = 8232,
    parameter int CNT_W    = 14
) (
    input  logic clk,
    input  logic rst,
    input  logic line_valid,
    input  logic line_bit_in,
    input  logic se0,
    output logic data_out,
    output logic data_valid,
    output logic sync_found,
    output logic pkt_active,
    output logic eop,
    output logic stuff_err,
    output logic babble_err
);

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_t;

    // The SYNC window is SYNC_LEN bits wide, but its newest bit is always the
    // bit being decoded this strobe, so only the older SYNC_LEN-1 bits need
    // storage. A history of all ones can never be mistaken for SYNC.
    localparam int                HIST_W    = SYNC_LEN - 1;
    localparam logic [CNT_W-1:0]  BIT_LIMIT = CNT_W'(MAX_BITS);
    localparam logic [2:0]        STUFF_RUN = 3'd6;
    localparam logic [2:0]        RUN_MAX   = 3'd7;

    state_t             state;
    logic               prev_line;
    logic [2:0]         ones_cnt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [HIST_W-1:0]  sync_hist;

    logic               dec;
    logic               sync_match;
    logic [2:0]         ones_inc;
    logic [HIST_W-1:0]  hist_shift;

    // NRZI decode: no transition means a 1. SYNC is recognised when the
    // current decoded bit is 1 and every stored older bit is 0.
    always_comb begin
        dec        = (line_bit_in == prev_line);
        hist_shift = {sync_hist[HIST_W-2:0], dec};
        sync_match = dec && (sync_hist == '0);
        ones_inc   = (ones_cnt == RUN_MAX) ? RUN_MAX : ones_cnt + 3'd1;
    end

    // Single sequential block holding the hunt/data state machine and all
    // registered outputs. Pulse outputs default low every cycle so they can
    // only be high for the cycle after a qualifying strobe. An SE0 strobe
    // never yields a decoded bit; it re-references NRZI to J and clears the
    // stuffing run. Inside a packet the strobe handling follows a strict
    // priority: EOP, stuffed-bit drop, stuffing error, babble, payload bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            prev_line  <= 1'b1;
            ones_cnt   <= 3'd0;
            bit_cnt    <= '0;
            sync_hist  <= '1;
            data_out   <= 1'b0;
            data_valid <= 1'b0;
            sync_found <= 1'b0;
            pkt_active <= 1'b0;
            eop        <= 1'b0;
            stuff_err  <= 1'b0;
            babble_err <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            sync_found <= 1'b0;
            eop        <= 1'b0;
            stuff_err  <= 1'b0;
            babble_err <= 1'b0;

            if (line_valid) begin
                if (se0) begin
                    prev_line <= 1'b1;
                    ones_cnt  <= 3'd0;
                end else begin
                    prev_line <= line_bit_in;
                end

                case (state)
                    HUNT: begin
                        if (!se0) begin
                            sync_hist <= hist_shift;
                            if (sync_match) begin
                                sync_found <= 1'b1;
                                pkt_active <= 1'b1;
                                ones_cnt   <= 3'd1;
                                bit_cnt    <= '0;
                                sync_hist  <= '1;
                                state      <= DATA;
                            end
                        end
                    end

                    DATA: begin
                        if (se0) begin
                            eop        <= 1'b1;
                            pkt_active <= 1'b0;
                            sync_hist  <= '1;
                            state      <= HUNT;
                        end else if (ones_cnt == STUFF_RUN) begin
                            if (!dec) begin
                                ones_cnt <= 3'd0;
                            end else begin
                                stuff_err  <= 1'b1;
                                pkt_active <= 1'b0;
                                ones_cnt   <= 3'd0;
                                sync_hist  <= '1;
                                state      <= HUNT;
                            end
                        end else if (bit_cnt == BIT_LIMIT) begin
                            babble_err <= 1'b1;
                            pkt_active <= 1'b0;
                            ones_cnt   <= 3'd0;
                            sync_hist  <= '1;
                            state      <= HUNT;
                        end else begin
                            data_out   <= dec;
                            data_valid <= 1'b1;
                            bit_cnt    <= bit_cnt + CNT_W'(1);
                            ones_cnt   <= dec ? ones_inc : 3'd0;
                        end
                    end

                    default: begin
                        state <= HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_bit_frontend.sv
// ---------------------------------------------------------------------------
// tb_usb_rx_bit_frontend
//
// Drives decoded bit sequences (NRZI-encoded by the bench) into the front
// end and checks every output event against a reference model. The model
// keeps the decoded history, run of ones and payload length as plain
// variables/queues and pushes each expected event (with the cycle it must
// appear in) onto a scoreboard queue; a monitor process pops and compares
// whenever the DUT raises a pulse. Directed scenarios additionally check
// event counts against fixed values.
// ---------------------------------------------------------------------------
module tb_usb_rx_bit_frontend;

    localparam int SYNC_LEN = 8;
    localparam int MAX_BITS = 16;

    localparam logic [4:0] EV_SYNC   = 5'b10000;
    localparam logic [4:0] EV_DATA   = 5'b01000;
    localparam logic [4:0] EV_EOP    = 5'b00100;
    localparam logic [4:0] EV_STUFF  = 5'b00010;
    localparam logic [4:0] EV_BABBLE = 5'b00001;

    typedef struct {
        logic [4:0] kind;
        logic       data;
        int         cyc;
    } event_t;

    logic clk = 1'b0;
    logic rst;
    logic line_valid;
    logic line_bit_in;
    logic se0;
    logic data_out;
    logic data_valid;
    logic sync_found;
    logic pkt_active;
    logic eop;
    logic stuff_err;
    logic babble_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    int n_sync = 0;
    int n_data = 0;
    int n_eop = 0;
    int n_stuff = 0;
    int n_babble = 0;
    int s_sync, s_data, s_eop, s_stuff, s_babble;

    event_t exp_q[$];

    bit m_prev;
    int m_run;
    bit m_in_pkt;
    bit m_hist[$];
    int m_emitted;
    bit m_last;
    bit tx_prev;

    usb_rx_bit_frontend #(
        .SYNC_LEN (SYNC_LEN),
        .MAX_BITS (MAX_BITS),
        .CNT_W    (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .line_valid  (line_valid),
        .line_bit_in (line_bit_in),
        .se0         (se0),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .sync_found  (sync_found),
        .pkt_active  (pkt_active),
        .eop         (eop),
        .stuff_err   (stuff_err),
        .babble_err  (babble_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: reset to idle J with no packet in progress.
    task automatic modelReset();
        m_prev = 1'b1;
        m_run = 0;
        m_in_pkt = 1'b0;
        m_hist.delete();
        m_emitted = 0;
        m_last = 1'b0;
        tx_prev = 1'b1;
        exp_q.delete();
    endtask

    task automatic pushEvent(input logic [4:0] kind, input logic d);
        event_t e;
        e.kind = kind;
        e.data = d;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic leavePacket();
        m_in_pkt = 1'b0;
        m_hist.delete();
    endtask

    // Reference model for one strobe, written from the protocol rules.
    task automatic modelStrobe(input logic b, input logic s);
        bit d;
        int zeros;
        if (s) begin
            m_prev = 1'b1;
            m_run = 0;
            if (m_in_pkt) begin
                pushEvent(EV_EOP, 1'b0);
                leavePacket();
            end
            return;
        end
        d = (b == m_prev);
        m_prev = b;
        if (!m_in_pkt) begin
            m_hist.push_back(d);
            if (m_hist.size() > SYNC_LEN) void'(m_hist.pop_front());
            if (m_hist.size() == SYNC_LEN && m_hist[SYNC_LEN-1] == 1'b1) begin
                zeros = 0;
                for (int i = 0; i < SYNC_LEN - 1; i++)
                    if (m_hist[i] == 1'b0) zeros++;
                if (zeros == SYNC_LEN - 1) begin
                    pushEvent(EV_SYNC, 1'b0);
                    m_in_pkt = 1'b1;
                    m_run = 1;
                    m_emitted = 0;
                    m_hist.delete();
                end
            end
        end else if (m_run == 6) begin
            if (!d) begin
                m_run = 0;
            end else begin
                pushEvent(EV_STUFF, 1'b0);
                leavePacket();
            end
        end else if (m_emitted == MAX_BITS) begin
            pushEvent(EV_BABBLE, 1'b0);
            leavePacket();
        end else begin
            pushEvent(EV_DATA, d);
            m_emitted++;
            m_last = d;
            m_run = d ? m_run + 1 : 0;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Inputs change just after the falling edge, once the monitor has sampled.
    task automatic applyStimulus(input logic r, input logic v, input logic b, input logic s);
        @(negedge clk);
        #1;
        rst = r;
        line_valid = v;
        line_bit_in = b;
        se0 = s;
        if (r) modelReset();
        else if (v) modelStrobe(b, s);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic sendBit(input bit d, input int gap);
        logic line;
        line = d ? tx_prev : ~tx_prev;
        tx_prev = line;
        applyStimulus(1'b0, 1'b1, line, 1'b0);
        idleCycles(gap);
    endtask

    task automatic sendSe0(input int gap);
        applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
        tx_prev = 1'b1;
        idleCycles(gap);
    endtask

    task automatic sendSync(input int gap);
        for (int i = 0; i < SYNC_LEN - 1; i++) sendBit(1'b0, gap);
        sendBit(1'b1, gap);
    endtask

    task automatic takeSnap();
        s_sync = n_sync;
        s_data = n_data;
        s_eop = n_eop;
        s_stuff = n_stuff;
        s_babble = n_babble;
    endtask

    task automatic checkCounts(input string name, input int ds, input int dd,
                               input int de, input int dst, input int db);
        idleCycles(2);
        checkOutput({name, "_sync"}, n_sync - s_sync, ds);
        checkOutput({name, "_data"}, n_data - s_data, dd);
        checkOutput({name, "_eop"}, n_eop - s_eop, de);
        checkOutput({name, "_stuff"}, n_stuff - s_stuff, dst);
        checkOutput({name, "_babble"}, n_babble - s_babble, db);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_data_out"}, int'(data_out), 0);
        checkOutput({name, "_data_valid"}, int'(data_valid), 0);
        checkOutput({name, "_sync_found"}, int'(sync_found), 0);
        checkOutput({name, "_pkt_active"}, int'(pkt_active), 0);
        checkOutput({name, "_eop"}, int'(eop), 0);
        checkOutput({name, "_stuff_err"}, int'(stuff_err), 0);
        checkOutput({name, "_babble_err"}, int'(babble_err), 0);
    endtask

    // Monitor: compares level outputs every cycle and pops the scoreboard
    // whenever any pulse output is raised; also flags expected events that
    // never appeared by their cycle.
    task automatic monitorLoop();
        logic [4:0] pulses;
        event_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                pulses = {sync_found, data_valid, eop, stuff_err, babble_err};
                checks++;
                if (pkt_active !== m_in_pkt) begin
                    errors++;
                    $display("[TB] FAIL pkt_active at cycle %0d: got %b expected %b", cyc, pkt_active, m_in_pkt);
                end
                checks++;
                if (data_out !== m_last) begin
                    errors++;
                    $display("[TB] FAIL data_out_hold at cycle %0d: got %b expected %b", cyc, data_out, m_last);
                end
                if (pulses !== 5'b0) begin
                    if (sync_found === 1'b1) n_sync++;
                    if (data_valid === 1'b1) n_data++;
                    if (eop === 1'b1) n_eop++;
                    if (stuff_err === 1'b1) n_stuff++;
                    if (babble_err === 1'b1) n_babble++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_event at cycle %0d: got pulses %b expected none", cyc, pulses);
                    end else begin
                        e = exp_q.pop_front();
                        if (pulses !== e.kind || e.cyc != cyc ||
                            (e.kind == EV_DATA && data_out !== e.data)) begin
                            errors++;
                            $display("[TB] FAIL event at cycle %0d: got pulses %b data %b expected pulses %b data %b cycle %0d",
                                     cyc, pulses, data_out, e.kind, e.data, e.cyc);
                        end
                    end
                end
                while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("[TB] FAIL missing_event at cycle %0d: got pulses %b expected pulses %b",
                             cyc, pulses, e.kind);
                end
            end
        end
    endtask

    function automatic int gapLen();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    initial begin
        bit nak[8];
        int run;
        int len;
        bit stuff_ok;
        bit d;
        nak = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        rst = 1'b1;
        line_valid = 1'b0;
        line_bit_in = 1'b0;
        se0 = 1'b0;
        modelReset();
        fork
            monitorLoop();
        join_none

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkAllZero("reset");
        mon_en = 1'b1;

        $display("[TB] T1 SYNC + NAK");
        takeSnap();
        idleCycles(2);
        sendSync(0);
        foreach (nak[i]) sendBit(nak[i], 0);
        sendSe0(0);
        checkCounts("t1", 1, 8, 1, 0, 0);

        $display("[TB] T2 bit stuffing");
        takeSnap();
        sendSync(0);
        for (int i = 0; i < 5; i++) sendBit(1'b1, 0);
        sendBit(1'b0, 0);
        sendBit(1'b1, 0);
        sendBit(1'b0, 0);
        sendSe0(0);
        checkCounts("t2", 1, 7, 1, 0, 0);

        $display("[TB] T3 stuff error and resync");
        takeSnap();
        sendSync(0);
        for (int i = 0; i < 6; i++) sendBit(1'b1, 0);
        checkCounts("t3", 1, 5, 0, 1, 0);
        takeSnap();
        sendSync(0);
        sendBit(1'b0, 0);
        sendSe0(0);
        checkCounts("t3_resync", 1, 1, 1, 0, 0);

        $display("[TB] T4 babble");
        takeSnap();
        sendSync(0);
        for (int i = 0; i < MAX_BITS + 1; i++) sendBit(1'(i % 2), 0);
        sendSe0(0);
        checkCounts("t4", 1, MAX_BITS, 0, 0, 1);

        $display("[TB] T5 gaps and mid-packet reset");
        takeSnap();
        sendSync(3);
        foreach (nak[i]) sendBit(nak[i], 3);
        sendSe0(3);
        checkCounts("t5_gaps", 1, 8, 1, 0, 0);
        takeSnap();
        sendSync(0);
        sendBit(1'b1, 0);
        sendBit(1'b0, 0);
        sendBit(1'b1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkAllZero("t5_reset");
        checkCounts("t5_reset", 1, 3, 0, 0, 0);
        takeSnap();
        sendSync(0);
        sendSe0(0);
        checkCounts("t5_resume", 1, 0, 1, 0, 0);

        $display("[TB] random packets");
        for (int p = 0; p < 300; p++) begin
            for (int i = 0; i < int'($urandom_range(0, 4)); i++)
                sendBit(1'($urandom_range(0, 1)), gapLen());
            sendSync(gapLen());
            run = 1;
            len = $urandom_range(0, 24);
            stuff_ok = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                d = ($urandom_range(0, 3) != 0);
                sendBit(d, gapLen());
                run = d ? run + 1 : 0;
                if (stuff_ok && run == 6) begin
                    sendBit(1'b0, gapLen());
                    run = 0;
                end
                if ($urandom_range(0, 40) == 0) sendSe0(gapLen());
            end
            if ($urandom_range(0, 4) != 0) sendSe0(gapLen());
            if ($urandom_range(0, 30) == 0) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        end

        idleCycles(3);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
